// File: rtl/r_empty_if.sv
// ============================================================================
// Module   : r_empty_if
// Brief    : Read-side bus of the async FIFO: write pointer in, read status out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface r_empty_if #(
    parameter int ADDR_SIZE = 3
);
    logic [ADDR_SIZE:0]   w_ptr;
    logic                 r_en;
    logic [ADDR_SIZE-1:0] r_addr;
    logic [ADDR_SIZE:0]   r_ptr;
    logic                 empty;
    logic                 almost_empty;
    logic [ADDR_SIZE:0]   r_level;
    logic                 underflow;

    modport slave (
        input  w_ptr, r_en,
        output r_addr, r_ptr, empty, almost_empty, r_level, underflow
    );

    modport master (
        output w_ptr, r_en,
        input  r_addr, r_ptr, empty, almost_empty, r_level, underflow
    );
endinterface

`default_nettype wire

// File: rtl/r_empty.sv
// ============================================================================
// Module   : r_empty
// Brief    : Async FIFO read-domain pointer, empty/almost-empty/level/underflow.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module r_empty #(
    parameter int ADDR_SIZE = 3,
    parameter int AE_LEVEL  = 1
) (
    input  wire logic  clk,
    input  wire logic  rst,
    r_empty_if.slave   bus
);
    localparam int                 c_PTR_W    = ADDR_SIZE + 1;
    localparam logic [c_PTR_W-1:0] c_AE_LEVEL = c_PTR_W'(AE_LEVEL);

    logic [c_PTR_W-1:0] r_w_s1;
    logic [c_PTR_W-1:0] r_w_s2;
    logic [c_PTR_W-1:0] r_bin;
    logic [c_PTR_W-1:0] r_gray;
    logic               r_is_empty;
    logic               r_almost_empty;
    logic [c_PTR_W-1:0] r_level;
    logic               r_underflow;

    logic               w_accept;
    logic [c_PTR_W-1:0] w_bin_next;
    logic [c_PTR_W-1:0] w_gray_next;
    logic [c_PTR_W-1:0] w_w_bin;
    logic [c_PTR_W-1:0] w_level_next;
    logic               w_empty_next;
    logic               w_ae_next;

    // Accept uses the registered empty so nothing here is combinational in r_en
    // at the outputs; every status output is a flop.
    assign w_accept     = bus.r_en & ~r_is_empty;
    assign w_bin_next   = r_bin + {{ADDR_SIZE{1'b0}}, w_accept};
    assign w_gray_next  = w_bin_next ^ (w_bin_next >> 1);
    assign w_empty_next = (w_gray_next == r_w_s2);

    always_comb begin
        w_w_bin = r_w_s2;
        for (int i = 1; i < c_PTR_W; i++) begin
            w_w_bin = w_w_bin ^ (r_w_s2 >> i);
        end
    end

    assign w_level_next = w_w_bin - w_bin_next;
    assign w_ae_next    = w_empty_next | (w_level_next <= c_AE_LEVEL);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_w_s1         <= '0;
            r_w_s2         <= '0;
            r_bin          <= '0;
            r_gray         <= '0;
            r_is_empty     <= 1'b1;
            r_almost_empty <= 1'b1;
            r_level        <= '0;
            r_underflow    <= 1'b0;
        end else begin
            r_w_s1         <= bus.w_ptr;
            r_w_s2         <= r_w_s1;
            r_bin          <= w_bin_next;
            r_gray         <= w_gray_next;
            r_is_empty     <= w_empty_next;
            r_almost_empty <= w_ae_next;
            r_level        <= w_level_next;
            r_underflow    <= bus.r_en & r_is_empty;
        end
    end

    assign bus.r_addr       = r_bin[ADDR_SIZE-1:0];
    assign bus.r_ptr        = r_gray;
    assign bus.empty        = r_is_empty;
    assign bus.almost_empty = r_almost_empty;
    assign bus.r_level      = r_level;
    assign bus.underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_r_empty.sv
// ============================================================================
// Module   : tb_r_empty
// Brief    : Directed-vector scoreboard bench for r_empty (ADDR_SIZE=3, AE_LEVEL=1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_r_empty;
    typedef struct packed {
        logic       rst;
        logic [3:0] w;
        logic       ren;
        logic [2:0] addr;
        logic [3:0] ptr;
        logic       e;
        logic       ae;
        logic [3:0] lvl;
        logic       uf;
    } vec_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    event ev_rst;

    vec_t vecs[$];
    vec_t exp_q[$];

    r_empty_if #(.ADDR_SIZE(3)) bus ();

    r_empty #(.ADDR_SIZE(3), .AE_LEVEL(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] w, input logic ren,
                                input logic [2:0] a, input logic [3:0] p, input logic e,
                                input logic ae, input logic [3:0] l, input logic uf);
        vec_t v;
        v = '{rst: r, w: w, ren: ren, addr: a, ptr: p, e: e, ae: ae, lvl: l, uf: uf};
        return v;
    endfunction

    // Monitor: outputs are sampled 1 time unit after each active edge.
    initial begin
        vec_t x;
        int   idx;
        idx = 0;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                n_cmp++;
                if (bus.r_addr !== x.addr || bus.r_ptr !== x.ptr || bus.empty !== x.e ||
                    bus.almost_empty !== x.ae || bus.r_level !== x.lvl || bus.underflow !== x.uf) begin
                    n_bad++;
                    $display("FAIL vec%0d: got addr=%0d ptr=%b empty=%b ae=%b lvl=%0d uf=%b, want addr=%0d ptr=%b empty=%b ae=%b lvl=%0d uf=%b",
                             idx, bus.r_addr, bus.r_ptr, bus.empty, bus.almost_empty, bus.r_level, bus.underflow,
                             x.addr, x.ptr, x.e, x.ae, x.lvl, x.uf);
                end
                idx++;
            end
        end
    end

    // Asynchronous reset: values must appear before any clock edge.
    initial begin
        forever begin
            @(ev_rst);
            n_cmp++;
            if (bus.r_addr !== 3'd0 || bus.r_ptr !== 4'b0000 || bus.empty !== 1'b1 ||
                bus.almost_empty !== 1'b1 || bus.r_level !== 4'd0 || bus.underflow !== 1'b0) begin
                n_bad++;
                $display("FAIL async_reset: got addr=%0d ptr=%b empty=%b ae=%b lvl=%0d uf=%b, want 0 0000 1 1 0 0",
                         bus.r_addr, bus.r_ptr, bus.empty, bus.almost_empty, bus.r_level, bus.underflow);
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.w_ptr = 4'b0000;
        bus.r_en = 1'b0;

        //               rst  w_ptr   ren addr ptr     e  ae lvl  uf
        vecs.push_back(mk(0, 4'b0000, 0, 3'd0, 4'b0000, 1, 1, 4'd0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 3'd0, 4'b0000, 1, 1, 4'd0, 0));
        vecs.push_back(mk(1, 4'b0000, 0, 3'd0, 4'b0000, 1, 1, 4'd0, 0));
        // write visibility: one entry, then two
        vecs.push_back(mk(1, 4'b0001, 0, 3'd0, 4'b0000, 1, 1, 4'd0, 0));
        vecs.push_back(mk(1, 4'b0001, 0, 3'd0, 4'b0000, 1, 1, 4'd0, 0));
        vecs.push_back(mk(1, 4'b0001, 0, 3'd0, 4'b0000, 0, 1, 4'd1, 0));
        vecs.push_back(mk(1, 4'b0011, 0, 3'd0, 4'b0000, 0, 1, 4'd1, 0));
        vecs.push_back(mk(1, 4'b0011, 0, 3'd0, 4'b0000, 0, 1, 4'd1, 0));
        vecs.push_back(mk(1, 4'b0011, 0, 3'd0, 4'b0000, 0, 0, 4'd2, 0));
        // drain four entries
        vecs.push_back(mk(1, 4'b0110, 0, 3'd0, 4'b0000, 0, 0, 4'd2, 0));
        vecs.push_back(mk(1, 4'b0110, 0, 3'd0, 4'b0000, 0, 0, 4'd2, 0));
        vecs.push_back(mk(1, 4'b0110, 0, 3'd0, 4'b0000, 0, 0, 4'd4, 0));
        vecs.push_back(mk(1, 4'b0110, 1, 3'd1, 4'b0001, 0, 0, 4'd3, 0));
        vecs.push_back(mk(1, 4'b0110, 1, 3'd2, 4'b0011, 0, 0, 4'd2, 0));
        vecs.push_back(mk(1, 4'b0110, 1, 3'd3, 4'b0010, 0, 1, 4'd1, 0));
        vecs.push_back(mk(1, 4'b0110, 1, 3'd4, 4'b0110, 1, 1, 4'd0, 0));
        // underflow: three rejected reads
        vecs.push_back(mk(1, 4'b0110, 1, 3'd4, 4'b0110, 1, 1, 4'd0, 1));
        vecs.push_back(mk(1, 4'b0110, 1, 3'd4, 4'b0110, 1, 1, 4'd0, 1));
        vecs.push_back(mk(1, 4'b0110, 1, 3'd4, 4'b0110, 1, 1, 4'd0, 1));
        vecs.push_back(mk(1, 4'b0110, 0, 3'd4, 4'b0110, 1, 1, 4'd0, 0));
        // mid-operation reset, then full FIFO and wrap
        vecs.push_back(mk(0, 4'b0000, 0, 3'd0, 4'b0000, 1, 1, 4'd0, 0));
        vecs.push_back(mk(1, 4'b1100, 0, 3'd0, 4'b0000, 1, 1, 4'd0, 0));
        vecs.push_back(mk(1, 4'b1100, 0, 3'd0, 4'b0000, 1, 1, 4'd0, 0));
        vecs.push_back(mk(1, 4'b1100, 0, 3'd0, 4'b0000, 0, 0, 4'd8, 0));
        vecs.push_back(mk(1, 4'b1100, 1, 3'd1, 4'b0001, 0, 0, 4'd7, 0));
        vecs.push_back(mk(1, 4'b1100, 1, 3'd2, 4'b0011, 0, 0, 4'd6, 0));
        vecs.push_back(mk(1, 4'b1100, 1, 3'd3, 4'b0010, 0, 0, 4'd5, 0));
        vecs.push_back(mk(1, 4'b1100, 1, 3'd4, 4'b0110, 0, 0, 4'd4, 0));
        vecs.push_back(mk(1, 4'b1100, 1, 3'd5, 4'b0111, 0, 0, 4'd3, 0));
        vecs.push_back(mk(1, 4'b1100, 1, 3'd6, 4'b0101, 0, 0, 4'd2, 0));
        vecs.push_back(mk(1, 4'b1100, 1, 3'd7, 4'b0100, 0, 1, 4'd1, 0));
        vecs.push_back(mk(1, 4'b1100, 1, 3'd0, 4'b1100, 1, 1, 4'd0, 0));
        vecs.push_back(mk(1, 4'b1101, 0, 3'd0, 4'b1100, 1, 1, 4'd0, 0));
        vecs.push_back(mk(1, 4'b1101, 0, 3'd0, 4'b1100, 1, 1, 4'd0, 0));
        vecs.push_back(mk(1, 4'b1101, 0, 3'd0, 4'b1100, 0, 1, 4'd1, 0));
        // build level 2, then read on the edge the next write becomes visible
        vecs.push_back(mk(1, 4'b1111, 0, 3'd0, 4'b1100, 0, 1, 4'd1, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 3'd0, 4'b1100, 0, 1, 4'd1, 0));
        vecs.push_back(mk(1, 4'b1111, 0, 3'd0, 4'b1100, 0, 0, 4'd2, 0));
        vecs.push_back(mk(1, 4'b1110, 0, 3'd0, 4'b1100, 0, 0, 4'd2, 0));
        vecs.push_back(mk(1, 4'b1110, 0, 3'd0, 4'b1100, 0, 0, 4'd2, 0));
        vecs.push_back(mk(1, 4'b1110, 1, 3'd1, 4'b1101, 0, 0, 4'd2, 0));
        vecs.push_back(mk(1, 4'b1110, 0, 3'd1, 4'b1101, 0, 0, 4'd2, 0));

        // Inputs change on the falling edge, i.e. mid-clock.
        foreach (vecs[i]) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            bus.w_ptr = vecs[i].w;
            bus.r_en  = vecs[i].ren;
            exp_q.push_back(vecs[i]);
            if (!vecs[i].rst) begin
                #1;
                -> ev_rst;
            end
        end

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_queue: got %0d pending, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
